dec_output_ctrl_pipe: RTL

DEC_OUTPUT_CTRL_PIPE -- requirements
Module: dec_output_ctrl_pipe

---
 rtl/dec_output_ctrl_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/dec_output_ctrl_pipe.sv
// Decoder output stage: classifies each accepted word from the syndrome flags,
// optionally corrects a single-bit error, buffers the result in a 2-entry FIFO
// and keeps saturating statistics of single and uncorrectable errors.
module dec_output_ctrl_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int COL_WIDTH  = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] codeword,
  input  logic                  no_error,
  input  logic                  single_error,
  input  logic [COL_WIDTH-1:0]  err_col,
  input  logic                  correct_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic [CNT_WIDTH-1:0]  single_cnt,
  output logic [CNT_WIDTH-1:0]  double_cnt,
  input  logic                  cnt_clr
);

  localparam logic [1:0] CLS_NONE   = 2'b00;
  localparam logic [1:0] CLS_SINGLE = 2'b01;
  localparam logic [1:0] CLS_DOUBLE = 2'b10;
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam logic [31:0] DW_U = 32'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] flip_mask;
  logic [DATA_WIDTH-1:0] corr_data;
  logic [1:0]            corr_cls;
  logic                  col_in_range;

  logic [ENTRY_W-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         occ;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // An err_col beyond the data width points at a check bit: nothing to flip.
  assign col_in_range = (32'(err_col) < DW_U);
  assign flip_mask    = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << err_col;

  // Classify and correct the presented word; no_error outranks single_error.
  always_comb begin
    corr_data = '0;
    corr_cls  = CLS_DOUBLE;
    if (no_error) begin
      corr_data = codeword;
      corr_cls  = CLS_NONE;
    end else if (single_error) begin
      corr_cls  = CLS_SINGLE;
      corr_data = (correct_en && col_in_range) ? (codeword ^ flip_mask) : codeword;
    end
  end

  // Handshake depends only on reset and occupancy, never on out_ready.
  assign in_ready  = rst && (occ != 2'd2);
  assign out_valid = rst && (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head          = fifo_mem[rd_ptr];
  assign data_out      = out_valid ? head[ENTRY_W-1:2] : '0;
  assign num_of_errors = out_valid ? head[1:0] : CLS_NONE;

  // FIFO storage; contents need no reset because out_valid masks them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {corr_data, corr_cls};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Saturating error statistics counted at acceptance; clear wins over increment.
  always_ff @(posedge clk) begin
    if (!rst || cnt_clr) begin
      single_cnt <= '0;
      double_cnt <= '0;
    end else if (push) begin
      if (corr_cls == CLS_SINGLE && single_cnt != CNT_MAX) begin
        single_cnt <= single_cnt + 1'b1;
      end
      if (corr_cls == CLS_DOUBLE && double_cnt != CNT_MAX) begin
        double_cnt <= double_cnt + 1'b1;
      end
    end
  end

endmodule
